execute_wb: RTL and testbench

EXECUTE_WB -- requirements
Module: execute_wb

---
 rtl/exec_pkg.sv | 25 ++
 rtl/shift_add_mul.sv | 65 ++++++
 rtl/execute_wb.sv | 132 +++++++++++++
 tb/tb_execute_wb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute/writeback stage: op-codes, FSM states
// and the iteration count of the shift-add multiplier.
package exec_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLT = 3'b101,
      OP_MUL = 3'b110,
      OP_SHL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      WB   = 2'd2
   } state_e;

   localparam int unsigned MUL_STEPS = 8;
   localparam int unsigned MUL_CNT_W = $clog2(MUL_STEPS);

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier, one step per enabled clock. product_o shows
// the accumulator value after the current step so the caller can capture it
// on the same edge that done_o is raised.
module shift_add_mul
   import exec_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] mcand_i,
   input  logic [WIDTH-1:0] mplier_i,
   output logic [WIDTH-1:0] product_o,
   output logic             done_o
);

   localparam logic [MUL_CNT_W-1:0] LAST_STEP = MUL_CNT_W'(MUL_STEPS - 1);

   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (load_i) begin
         mcand_d  = mcand_i;
         mplier_d = mplier_i;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (step_i) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + MUL_CNT_W'(1);
      end
   end

   assign product_o = acc_d;
   assign done_o    = step_i && (cnt_q == LAST_STEP);

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/execute_wb.sv
// Execute + writeback stage: single-cycle ALU ops, 8-step iterative multiply,
// then a one-cycle register-file write pulse.
module execute_wb
   import exec_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] Data1,
   input  logic [WIDTH-1:0] Data2,
   input  logic [2:0]       DestReg,
   output logic             busy,
   output logic [2:0]       WriteReg,
   output logic [WIDTH-1:0] WriteData,
   output logic             RegWrite,
   output logic             Zero,
   output logic             Carry
);

   state_e           state_q;
   logic [2:0]       dest_q;
   logic [2:0]       write_reg_q;
   logic [WIDTH-1:0] write_data_q;
   logic             reg_write_q;
   logic             zero_q;
   logic             carry_q;

   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic [WIDTH:0]   ext;
   logic             accept;
   logic             mul_load;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   assign accept   = (state_q == IDLE) && start;
   assign mul_load = accept && (op_e'(op) == OP_MUL);

   // Bit WIDTH of ext carries the ADD carry, SUB borrow or last SHL bit shifted out.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      ext       = '0;
      case (op_e'(op))
         OP_ADD: begin
            ext       = {1'b0, Data1} + {1'b0, Data2};
            alu_res   = ext[WIDTH-1:0];
            alu_carry = ext[WIDTH];
         end
         OP_SUB: begin
            ext       = {1'b0, Data1} - {1'b0, Data2};
            alu_res   = ext[WIDTH-1:0];
            alu_carry = ext[WIDTH];
         end
         OP_AND: alu_res = Data1 & Data2;
         OP_OR:  alu_res = Data1 | Data2;
         OP_XOR: alu_res = Data1 ^ Data2;
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (Data1 < Data2)};
         OP_MUL: alu_res = '0;
         OP_SHL: begin
            ext       = {1'b0, Data1} << Data2[2:0];
            alu_res   = ext[WIDTH-1:0];
            alu_carry = ext[WIDTH];
         end
      endcase
   end

   shift_add_mul #(.WIDTH(WIDTH)) u_mul (
      .clock     (clock),
      .resetn    (resetn),
      .load_i    (mul_load),
      .step_i    (state_q == MUL),
      .mcand_i   (Data1),
      .mplier_i  (Data2),
      .product_o (mul_product),
      .done_o    (mul_done)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         dest_q       <= '0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         reg_write_q  <= 1'b0;
         zero_q       <= 1'b0;
         carry_q      <= 1'b0;
      end else begin
         reg_write_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  dest_q <= DestReg;
                  if (op_e'(op) == OP_MUL) begin
                     state_q <= MUL;
                  end else begin
                     state_q      <= WB;
                     write_reg_q  <= DestReg;
                     write_data_q <= alu_res;
                     zero_q       <= (alu_res == '0);
                     carry_q      <= alu_carry;
                     reg_write_q  <= (DestReg != 3'd0);
                  end
               end
            end
            MUL: begin
               if (mul_done) begin
                  state_q      <= WB;
                  write_reg_q  <= dest_q;
                  write_data_q <= mul_product;
                  zero_q       <= (mul_product == '0);
                  carry_q      <= 1'b0;
                  reg_write_q  <= (dest_q != 3'd0);
               end
            end
            WB:      state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign WriteReg  = write_reg_q;
   assign WriteData = write_data_q;
   assign RegWrite  = reg_write_q;
   assign Zero      = zero_q;
   assign Carry     = carry_q;

endmodule

// File: tb/tb_execute_wb.sv
// Directed bench for execute_wb: a vector table run through one transaction
// task, plus hand-written sequences for busy-start, reset abort and back-to-back.
module tb_execute_wb;

   localparam logic [2:0] T_ADD = 3'b000;
   localparam logic [2:0] T_SUB = 3'b001;
   localparam logic [2:0] T_AND = 3'b010;
   localparam logic [2:0] T_OR  = 3'b011;
   localparam logic [2:0] T_XOR = 3'b100;
   localparam logic [2:0] T_SLT = 3'b101;
   localparam logic [2:0] T_MUL = 3'b110;
   localparam logic [2:0] T_SHL = 3'b111;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic [2:0] op = 3'b000;
   logic [7:0] Data1 = 8'h00;
   logic [7:0] Data2 = 8'h00;
   logic [2:0] DestReg = 3'd0;
   logic       busy;
   logic [2:0] WriteReg;
   logic [7:0] WriteData;
   logic       RegWrite;
   logic       Zero;
   logic       Carry;

   int checks = 0;
   int errors = 0;

   execute_wb #(.WIDTH(8)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .start     (start),
      .op        (op),
      .Data1     (Data1),
      .Data2     (Data2),
      .DestReg   (DestReg),
      .busy      (busy),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .RegWrite  (RegWrite),
      .Zero      (Zero),
      .Carry     (Carry)
   );

   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [7:0] d1;
      logic [7:0] d2;
      logic [2:0] dest;
      logic [7:0] wd;
      logic       z;
      logic       c;
      int         lat;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Accept one op, scramble the operands, then watch until busy drops.
   task automatic run_vec(input vec_t v);
      int busy_n;
      int pulses;
      int wr_k;
      logic [2:0] wr_reg;
      busy_n = 0;
      pulses = 0;
      wr_k   = -1;
      wr_reg = 3'd0;
      @(negedge clock);
      op = v.op; Data1 = v.d1; Data2 = v.d2; DestReg = v.dest; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; Data1 = ~v.d1; Data2 = ~v.d2; DestReg = ~v.dest;
      for (int k = 0; k < 16; k++) begin
         if (!busy) break;
         busy_n++;
         if (RegWrite) begin
            pulses++;
            wr_k   = k;
            wr_reg = WriteReg;
         end
         @(posedge clock); #1;
      end
      check({v.name, " busy_cycles"}, busy_n, v.lat);
      check({v.name, " regwrite_pulses"}, pulses, (v.dest != 3'd0) ? 1 : 0);
      if (v.dest != 3'd0) begin
         check({v.name, " regwrite_cycle"}, wr_k, v.lat - 1);
         check({v.name, " writereg_at_pulse"}, wr_reg, v.dest);
      end
      check({v.name, " WriteReg"}, WriteReg, v.dest);
      check({v.name, " WriteData"}, WriteData, v.wd);
      check({v.name, " Zero"}, Zero, v.z);
      check({v.name, " Carry"}, Carry, v.c);
      @(posedge clock); #1;
      check({v.name, " WriteData_held"}, WriteData, v.wd);
      check({v.name, " RegWrite_low"}, RegWrite, 1'b0);
   endtask

   initial begin
      int busy_n;
      int pulses;
      vec_t v;

      vecs[0]  = '{"add_carry",  T_ADD, 8'hF0, 8'h20, 3'd3, 8'h10, 1'b0, 1'b1, 1};
      vecs[1]  = '{"add_wrap0",  T_ADD, 8'hFF, 8'h01, 3'd3, 8'h00, 1'b1, 1'b1, 1};
      vecs[2]  = '{"sub_equal",  T_SUB, 8'h05, 8'h05, 3'd2, 8'h00, 1'b1, 1'b0, 1};
      vecs[3]  = '{"sub_borrow", T_SUB, 8'h03, 8'h05, 3'd2, 8'hFE, 1'b0, 1'b1, 1};
      vecs[4]  = '{"and_dest0",  T_AND, 8'hFF, 8'h0F, 3'd0, 8'h0F, 1'b0, 1'b0, 1};
      vecs[5]  = '{"or",         T_OR,  8'h50, 8'h0A, 3'd1, 8'h5A, 1'b0, 1'b0, 1};
      vecs[6]  = '{"xor_zero",   T_XOR, 8'hAA, 8'hAA, 3'd4, 8'h00, 1'b1, 1'b0, 1};
      vecs[7]  = '{"slt_true",   T_SLT, 8'h03, 8'h05, 3'd5, 8'h01, 1'b0, 1'b0, 1};
      vecs[8]  = '{"slt_false",  T_SLT, 8'h05, 8'h03, 3'd5, 8'h00, 1'b1, 1'b0, 1};
      vecs[9]  = '{"slt_equal",  T_SLT, 8'hFF, 8'hFF, 3'd5, 8'h00, 1'b1, 1'b0, 1};
      vecs[10] = '{"shl_1",      T_SHL, 8'h81, 8'h01, 3'd6, 8'h02, 1'b0, 1'b1, 1};
      vecs[11] = '{"shl_0",      T_SHL, 8'h81, 8'h08, 3'd6, 8'h81, 1'b0, 1'b0, 1};
      vecs[12] = '{"shl_7",      T_SHL, 8'h03, 8'h07, 3'd6, 8'h80, 1'b0, 1'b1, 1};
      vecs[13] = '{"mul_13x11",  T_MUL, 8'd13, 8'd11, 3'd7, 8'h8F, 1'b0, 1'b0, 9};
      vecs[14] = '{"mul_ffxff",  T_MUL, 8'hFF, 8'hFF, 3'd1, 8'h01, 1'b0, 1'b0, 9};
      vecs[15] = '{"mul_zero_d0",T_MUL, 8'h10, 8'h10, 3'd0, 8'h00, 1'b1, 1'b0, 9};

      // Reset state
      #12;
      check("rst busy", busy, 1'b0);
      check("rst RegWrite", RegWrite, 1'b0);
      check("rst WriteReg", WriteReg, 3'd0);
      check("rst WriteData", WriteData, 8'h00);
      check("rst Zero", Zero, 1'b0);
      check("rst Carry", Carry, 1'b0);
      @(posedge clock); #1;
      resetn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run_vec(vecs[i]);
      end

      // MUL with a start pulse while busy: must be ignored, not queued
      busy_n = 0;
      pulses = 0;
      @(negedge clock);
      op = T_MUL; Data1 = 8'd13; Data2 = 8'd11; DestReg = 3'd7; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (!busy) break;
         busy_n++;
         if (RegWrite) pulses++;
         if (k == 3) begin
            start = 1'b1; op = T_ADD; Data1 = 8'h01; Data2 = 8'h01; DestReg = 3'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clock); #1;
      end
      start = 1'b0;
      check("busystart busy_cycles", busy_n, 9);
      check("busystart pulses", pulses, 1);
      check("busystart WriteReg", WriteReg, 3'd7);
      check("busystart WriteData", WriteData, 8'h8F);
      @(posedge clock); #1;
      check("busystart not_queued", busy, 1'b0);

      // Reset in the middle of a MUL aborts it
      v = '{"pre_abort_add", T_ADD, 8'h12, 8'h34, 3'd5, 8'h46, 1'b0, 1'b0, 1};
      run_vec(v);
      @(negedge clock);
      op = T_MUL; Data1 = 8'd13; Data2 = 8'd11; DestReg = 3'd7; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      #3;
      resetn = 1'b0;
      #1;
      check("abort busy", busy, 1'b0);
      check("abort RegWrite", RegWrite, 1'b0);
      check("abort WriteReg", WriteReg, 3'd0);
      check("abort WriteData", WriteData, 8'h00);
      check("abort Zero", Zero, 1'b0);
      check("abort Carry", Carry, 1'b0);
      pulses = 0;
      repeat (2) begin
         @(posedge clock); #1;
         if (RegWrite) pulses++;
      end
      resetn = 1'b1;
      check("abort no_pulse", pulses, 0);
      v = '{"post_abort_add", T_ADD, 8'h0F, 8'h01, 3'd4, 8'h10, 1'b0, 1'b0, 1};
      run_vec(v);

      // start held high: XOR then SHL, one accept every 2 cycles
      @(negedge clock);
      op = T_XOR; Data1 = 8'h3C; Data2 = 8'h0F; DestReg = 3'd1; start = 1'b1;
      @(posedge clock); #1;
      op = T_SHL; Data1 = 8'h81; Data2 = 8'h01; DestReg = 3'd2;
      check("b2b xor RegWrite", RegWrite, 1'b1);
      check("b2b xor WriteReg", WriteReg, 3'd1);
      check("b2b xor WriteData", WriteData, 8'h33);
      @(posedge clock); #1;
      check("b2b gap busy", busy, 1'b0);
      check("b2b gap RegWrite", RegWrite, 1'b0);
      @(posedge clock); #1;
      start = 1'b0;
      check("b2b shl RegWrite", RegWrite, 1'b1);
      check("b2b shl WriteReg", WriteReg, 3'd2);
      check("b2b shl WriteData", WriteData, 8'h02);
      check("b2b shl Carry", Carry, 1'b1);
      @(posedge clock); #1;
      check("b2b end busy", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
